// File: rtl/mdio_pkg.sv
// rtl/mdio_pkg.sv - Shared FSM state type and frame constants for the MDIO responder.
package mdio_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_START,
    ST_OP,
    ST_PHYAD,
    ST_REGAD,
    ST_TA,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_SKIP
  } mdio_state_e;

  localparam logic [1:0] MDIO_OP_READ      = 2'b10;
  localparam logic [1:0] MDIO_OP_WRITE     = 2'b01;
  localparam int         MDIO_PREAMBLE_LEN = 32;
  localparam int         MDIO_DATA_BITS    = 16;
  localparam int         MDIO_SKIP_BITS    = MDIO_DATA_BITS + 2;

endpackage

// File: rtl/mdio_sync_edge.sv
// rtl/mdio_sync_edge.sv - MDC/MDIO synchronizer with a registered MDC rising-edge strobe.
module mdio_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mdc_i,
  input  logic mdio_i,
  output logic mdc_rise_o,
  output logic mdio_s_o
);

  logic [SYNC_STAGES-1:0] mdc_sync_q, mdc_sync_d;
  logic [SYNC_STAGES-1:0] mdio_sync_q, mdio_sync_d;
  logic                   mdc_prev_q, mdc_prev_d;
  logic                   rise_q, rise_d;
  logic                   mdio_smp_q, mdio_smp_d;

  // The MDIO sample is registered alongside the strobe so both describe the same MDC edge.
  always_comb begin
    mdc_sync_d  = {mdc_sync_q[SYNC_STAGES-2:0], mdc_i};
    mdio_sync_d = {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
    mdc_prev_d  = mdc_sync_q[SYNC_STAGES-1];
    rise_d      = mdc_sync_q[SYNC_STAGES-1] & ~mdc_prev_q;
    mdio_smp_d  = mdio_sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_sync_q  <= '0;
      mdio_sync_q <= '1;
      mdc_prev_q  <= 1'b0;
      rise_q      <= 1'b0;
      mdio_smp_q  <= 1'b1;
    end else begin
      mdc_sync_q  <= mdc_sync_d;
      mdio_sync_q <= mdio_sync_d;
      mdc_prev_q  <= mdc_prev_d;
      rise_q      <= rise_d;
      mdio_smp_q  <= mdio_smp_d;
    end
  end

  assign mdc_rise_o = rise_q;
  assign mdio_s_o   = mdio_smp_q;

endmodule

// File: rtl/mdio_responder.sv
// rtl/mdio_responder.sv - Clause 22 MDIO PHY-side target; MDIO_RESPONDER_BROADCAST_EN adds PHYAD 0 write matching.
module mdio_responder
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR    = 5'd1,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc_i,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  output logic        rd_req,
  output logic [4:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data
);

  localparam logic [5:0] PRE_FULL  = 6'(MDIO_PREAMBLE_LEN);
  localparam logic [4:0] DATA_LAST = 5'(MDIO_DATA_BITS - 1);
  localparam logic [4:0] SKIP_LAST = 5'(MDIO_SKIP_BITS - 1);

  logic        mdc_rise;
  logic        mdio_s;

  mdio_state_e state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        op_hi_q, op_hi_d;
  logic        is_read_q, is_read_d;
  logic        match_q, match_d;
  logic [4:0]  addr_sr_q, addr_sr_d;
  logic [4:0]  regad_q, regad_d;
  logic [15:0] sh_q, sh_d;

  logic        mdio_o_q, mdio_o_d;
  logic        mdio_oe_q, mdio_oe_d;
  logic        rd_req_q, rd_req_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;

  logic [4:0]  addr_full;
  logic        phy_hit;

  mdio_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .mdc_i     (mdc_i),
    .mdio_i    (mdio_i),
    .mdc_rise_o(mdc_rise),
    .mdio_s_o  (mdio_s)
  );

  // Address as it stands once the current bit is shifted in; serves PHYAD and REGAD alike.
  assign addr_full = {addr_sr_q[3:0], mdio_s};

`ifdef MDIO_RESPONDER_BROADCAST_EN
  assign phy_hit = (addr_full == PHY_ADDR) || ((addr_full == 5'd0) && !is_read_q);
`else
  assign phy_hit = (addr_full == PHY_ADDR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pre_cnt_q <= '0;
      bit_cnt_q <= '0;
      op_hi_q   <= 1'b0;
      is_read_q <= 1'b0;
      match_q   <= 1'b0;
      addr_sr_q <= '0;
      regad_q   <= '0;
      sh_q      <= '0;
      mdio_o_q  <= 1'b1;
      mdio_oe_q <= 1'b0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      op_hi_q   <= op_hi_d;
      is_read_q <= is_read_d;
      match_q   <= match_d;
      addr_sr_q <= addr_sr_d;
      regad_q   <= regad_d;
      sh_q      <= sh_d;
      mdio_o_q  <= mdio_o_d;
      mdio_oe_q <= mdio_oe_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    bit_cnt_d = bit_cnt_q;
    op_hi_d   = op_hi_q;
    is_read_d = is_read_q;
    match_d   = match_q;
    addr_sr_d = addr_sr_q;
    regad_d   = regad_q;
    sh_d      = sh_q;

    // Preamble only accumulates in IDLE, so every return there starts from zero.
    if (state_q != ST_IDLE) pre_cnt_d = '0;

    if (mdc_rise) begin
      case (state_q)
        ST_IDLE: begin
          if (mdio_s) begin
            if (pre_cnt_q != PRE_FULL) pre_cnt_d = pre_cnt_q + 6'd1;
          end else begin
            if (pre_cnt_q == PRE_FULL) state_d = ST_START;
            pre_cnt_d = '0;
          end
        end
        ST_START: begin
          bit_cnt_d = '0;
          state_d   = mdio_s ? ST_OP : ST_IDLE;
        end
        ST_OP: begin
          if (bit_cnt_q == 5'd0) begin
            op_hi_d   = mdio_s;
            bit_cnt_d = 5'd1;
          end else begin
            bit_cnt_d = '0;
            if ({op_hi_q, mdio_s} == MDIO_OP_READ) begin
              is_read_d = 1'b1;
              state_d   = ST_PHYAD;
            end else if ({op_hi_q, mdio_s} == MDIO_OP_WRITE) begin
              is_read_d = 1'b0;
              state_d   = ST_PHYAD;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_PHYAD: begin
          addr_sr_d = addr_full;
          if (bit_cnt_q == 5'd4) begin
            match_d   = phy_hit;
            bit_cnt_d = '0;
            state_d   = ST_REGAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_REGAD: begin
          addr_sr_d = addr_full;
          if (bit_cnt_q == 5'd4) begin
            regad_d   = addr_full;
            bit_cnt_d = '0;
            state_d   = match_q ? ST_TA : ST_SKIP;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_TA: begin
          if (bit_cnt_q == 5'd0) begin
            bit_cnt_d = 5'd1;
          end else begin
            bit_cnt_d = '0;
            if (is_read_q) begin
              sh_d    = rd_data;
              state_d = ST_RD_DATA;
            end else begin
              state_d = ST_WR_DATA;
            end
          end
        end
        ST_RD_DATA: begin
          sh_d = {sh_q[14:0], 1'b0};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_WR_DATA: begin
          sh_d = {sh_q[14:0], mdio_s};
          if (bit_cnt_q == DATA_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        ST_SKIP: begin
          if (bit_cnt_q == SKIP_LAST) begin
            bit_cnt_d = '0;
            state_d   = ST_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end
        default: begin
          bit_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    mdio_o_d  = mdio_o_q;
    mdio_oe_d = mdio_oe_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (mdc_rise) begin
      case (state_q)
        ST_REGAD: begin
          if ((bit_cnt_q == 5'd4) && match_q && is_read_q) begin
            rd_req_d  = 1'b1;
            rd_addr_d = addr_full;
          end
        end
        ST_TA: begin
          if (is_read_q) begin
            mdio_oe_d = 1'b1;
            mdio_o_d  = (bit_cnt_q == 5'd0) ? 1'b0 : rd_data[15];
          end
        end
        ST_RD_DATA: begin
          if (bit_cnt_q == DATA_LAST) begin
            mdio_oe_d = 1'b0;
            mdio_o_d  = 1'b1;
          end else begin
            mdio_o_d = sh_q[14];
          end
        end
        ST_WR_DATA: begin
          if (bit_cnt_q == DATA_LAST) begin
            wr_en_d   = 1'b1;
            wr_addr_d = regad_q;
            wr_data_d = {sh_q[14:0], mdio_s};
          end
        end
        default: begin
          mdio_oe_d = 1'b0;
          mdio_o_d  = 1'b1;
        end
      endcase
    end
  end

  assign mdio_o  = mdio_o_q;
  assign mdio_oe = mdio_oe_q;
  assign rd_req  = rd_req_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;

endmodule

// File: tb/tb_mdio_responder.sv
// tb/tb_mdio_responder.sv - Directed bench for mdio_responder acting as MDIO master with a pulled-up bus.
module tb_mdio_responder;

  logic        clk;
  logic        rst_n;
  logic        mdc;
  logic        m_en;
  logic        m_val;
  logic        mdio_bus;
  logic        mdio_o;
  logic        mdio_oe;
  logic        rd_req;
  logic [4:0]  rd_addr;
  logic [15:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  int          n_cmp;
  int          n_fail;
  int          rd_req_cnt;
  int          wr_en_cnt;
  int          oe_cnt;
  logic [4:0]  rd_addr_seen;
  logic [4:0]  wr_addr_seen;
  logic [15:0] wr_data_seen;

  int          rq0;
  int          wr0;
  int          oe0;
  logic [15:0] rv;
  logic        t1;
  logic        t2;

  mdio_responder #(
    .PHY_ADDR   (5'd1),
    .SYNC_STAGES(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .mdc_i  (mdc),
    .mdio_i (mdio_bus),
    .mdio_o (mdio_o),
    .mdio_oe(mdio_oe),
    .rd_req (rd_req),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  assign mdio_bus = mdio_oe ? mdio_o : (m_en ? m_val : 1'b1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    rd_req_cnt   = 0;
    wr_en_cnt    = 0;
    oe_cnt       = 0;
    rd_addr_seen = '0;
    wr_addr_seen = '0;
    wr_data_seen = '0;
  end

  always @(negedge clk) begin
    if (rd_req) begin
      rd_req_cnt   <= rd_req_cnt + 1;
      rd_addr_seen <= rd_addr;
    end
    if (wr_en) begin
      wr_en_cnt    <= wr_en_cnt + 1;
      wr_addr_seen <= wr_addr;
      wr_data_seen <= wr_data;
    end
    if (mdio_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic drive, output logic s, output logic oe_s);
    m_en  = drive;
    m_val = b;
    #80;
    s     = mdio_bus;
    oe_s  = mdio_oe;
    mdc   = 1'b1;
    #80;
    mdc   = 1'b0;
  endtask

  task automatic frame(input int pre_len, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] regad, input logic [15:0] wdata, input int rst_bit,
                       output logic [15:0] rd_val, output logic ta1_oe, output logic ta2_val);
    logic s;
    logic oe_s;
    rd_val  = '0;
    ta1_oe  = 1'b0;
    ta2_val = 1'b1;
    for (int i = 0; i < pre_len; i++) send_bit(1'b1, 1'b1, s, oe_s);
    send_bit(1'b0, 1'b1, s, oe_s);
    send_bit(1'b1, 1'b1, s, oe_s);
    for (int i = 1; i >= 0; i--) send_bit(op[i], 1'b1, s, oe_s);
    for (int i = 4; i >= 0; i--) send_bit(phy[i], 1'b1, s, oe_s);
    for (int i = 4; i >= 0; i--) send_bit(regad[i], 1'b1, s, oe_s);
    if (op == 2'b10) begin
      send_bit(1'b1, 1'b0, s, oe_s);
      ta1_oe = oe_s;
      send_bit(1'b1, 1'b0, s, oe_s);
      ta2_val = s;
      for (int i = 0; i < 16; i++) begin
        if (i == rst_bit) begin
          #40;
          check("oe_before_reset", 32'(mdio_oe), 32'd1);
          rst_n = 1'b0;
          #1;
          check("oe_in_reset", 32'(mdio_oe), 32'd0);
          check("mdio_o_in_reset", 32'(mdio_o), 32'd1);
          check("rd_addr_in_reset", 32'(rd_addr), 32'd0);
          #20;
          rst_n = 1'b1;
          #19;
          m_en  = 1'b1;
          m_val = 1'b1;
          return;
        end
        send_bit(1'b1, 1'b0, s, oe_s);
        rd_val = {rd_val[14:0], s};
      end
    end else begin
      send_bit(1'b1, 1'b1, s, oe_s);
      send_bit(1'b0, 1'b1, s, oe_s);
      for (int i = 15; i >= 0; i--) send_bit(wdata[i], 1'b1, s, oe_s);
    end
    m_en  = 1'b1;
    m_val = 1'b1;
  endtask

  initial begin
    n_cmp   = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    mdc     = 1'b0;
    m_en    = 1'b1;
    m_val   = 1'b1;
    rd_data = '0;
    #50;
    check("rst_mdio_o", 32'(mdio_o), 32'd1);
    check("rst_mdio_oe", 32'(mdio_oe), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_rd_addr", 32'(rd_addr), 32'd0);
    check("rst_wr_addr", 32'(wr_addr), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    #50;
    rst_n = 1'b1;
    #60;

    rd_data = 16'h0141;
    rq0 = rd_req_cnt;
    frame(32, 2'b10, 5'd1, 5'h02, 16'h0000, -1, rv, t1, t2);
    check("read_rd_req_count", 32'(rd_req_cnt - rq0), 32'd1);
    check("read_rd_addr", 32'(rd_addr_seen), 32'h02);
    check("read_ta1_oe", 32'(t1), 32'd0);
    check("read_ta2_value", 32'(t2), 32'd0);
    check("read_data", 32'(rv), 32'h0141);
    check("read_oe_released", 32'(mdio_oe), 32'd0);

    wr0 = wr_en_cnt;
    rq0 = rd_req_cnt;
    frame(32, 2'b01, 5'd1, 5'h00, 16'h1140, -1, rv, t1, t2);
    check("write_wr_en_count", 32'(wr_en_cnt - wr0), 32'd1);
    check("write_wr_addr", 32'(wr_addr_seen), 32'h00);
    check("write_wr_data", 32'(wr_data_seen), 32'h1140);
    check("write_no_rd_req", 32'(rd_req_cnt - rq0), 32'd0);

    rq0 = rd_req_cnt;
    oe0 = oe_cnt;
    frame(32, 2'b10, 5'd3, 5'h02, 16'h0000, -1, rv, t1, t2);
    check("mismatch_no_rd_req", 32'(rd_req_cnt - rq0), 32'd0);
    check("mismatch_oe_quiet", 32'(oe_cnt - oe0), 32'd0);

    rd_data = 16'hA5C3;
    rq0 = rd_req_cnt;
    frame(32, 2'b10, 5'd1, 5'h03, 16'h0000, -1, rv, t1, t2);
    check("after_mismatch_rd_req", 32'(rd_req_cnt - rq0), 32'd1);
    check("after_mismatch_rd_addr", 32'(rd_addr_seen), 32'h03);
    check("after_mismatch_data", 32'(rv), 32'hA5C3);

    wr0 = wr_en_cnt;
    frame(31, 2'b01, 5'd1, 5'h04, 16'h5555, -1, rv, t1, t2);
    check("short_preamble_no_wr", 32'(wr_en_cnt - wr0), 32'd0);

    wr0 = wr_en_cnt;
    rq0 = rd_req_cnt;
    oe0 = oe_cnt;
    frame(32, 2'b11, 5'd1, 5'h04, 16'hFFFF, -1, rv, t1, t2);
    check("bad_op_no_wr", 32'(wr_en_cnt - wr0), 32'd0);
    check("bad_op_no_rd", 32'(rd_req_cnt - rq0), 32'd0);
    check("bad_op_oe_quiet", 32'(oe_cnt - oe0), 32'd0);

    rd_data = 16'h1234;
    frame(32, 2'b10, 5'd1, 5'h02, 16'h0000, 8, rv, t1, t2);

    rd_data = 16'h7E81;
    rq0 = rd_req_cnt;
    frame(32, 2'b10, 5'd1, 5'h1F, 16'h0000, -1, rv, t1, t2);
    check("post_reset_rd_req", 32'(rd_req_cnt - rq0), 32'd1);
    check("post_reset_rd_addr", 32'(rd_addr_seen), 32'h1F);
    check("post_reset_data", 32'(rv), 32'h7E81);

    rq0 = rd_req_cnt;
    oe0 = oe_cnt;
    frame(32, 2'b10, 5'd0, 5'h02, 16'h0000, -1, rv, t1, t2);
    check("bcast_read_no_rd_req", 32'(rd_req_cnt - rq0), 32'd0);
    check("bcast_read_oe_quiet", 32'(oe_cnt - oe0), 32'd0);

    wr0 = wr_en_cnt;
    frame(32, 2'b01, 5'd0, 5'h09, 16'hBEEF, -1, rv, t1, t2);
`ifdef MDIO_RESPONDER_BROADCAST_EN
    check("bcast_write_wr_en", 32'(wr_en_cnt - wr0), 32'd1);
    check("bcast_write_wr_addr", 32'(wr_addr_seen), 32'h09);
    check("bcast_write_wr_data", 32'(wr_data_seen), 32'hBEEF);
`else
    check("bcast_write_no_wr_en", 32'(wr_en_cnt - wr0), 32'd0);
`endif

    #200;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
